// File: rtl/mux_arb_nbyw_pkg.sv
// Shared constants and types for the N-channel registered mux/arbiter.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } skid_state_t;

endpackage

// File: rtl/mux_arb_nbyw_if.sv
// Handshake bundle for mux_arb_nbyw: NCH producer channels in, one consumer port out.
interface mux_arb_nbyw_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4
);
  localparam int SELW = $clog2(NCH);

  logic                  mode;
  logic [SELW-1:0]       sel;
  logic [NCH-1:0]        in_valid;
  logic [NCH*WIDTH-1:0]  in_data;
  logic [NCH-1:0]        in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SELW-1:0]       out_chan;
  logic                  out_ready;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );

endinterface

// File: rtl/mux_arb_nbyw_arb.sv
// Combinational round-robin arbiter: first requester strictly after ptr, wrapping.
module rr_arbiter #(
  parameter  int NCH  = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  logic [2*NCH-1:0] rotated;

  // Doubling the request vector makes the wrap a plain right shift.
  always_comb begin
    rotated   = {req, req} >> (int'(ptr) + 1);
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int j = 0; j < NCH; j++) begin
      if (!gnt_valid && rotated[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SELW'((int'(ptr) + 1 + j) % NCH);
      end
    end
  end

endmodule

// File: rtl/mux_arb_nbyw.sv
// N-channel registered mux with explicit-select or round-robin grant.
// Define MUXARB_SKID_EN to add a one-entry skid register and cut the out_ready->in_ready path.
module mux_arb_nbyw
  import mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NCH   = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic          Clk,
  input  logic          reset,
  mux_arb_nbyw_if.slave bus
);

  logic             outValid_q;
  logic [WIDTH-1:0] outData_q;
  logic [SELW-1:0]  outChan_q;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             rrValid;
  logic [SELW-1:0]  rrIdx;
  logic             candValid;
  logic [SELW-1:0]  candIdx;
  logic [WIDTH-1:0] candData;
  logic             spaceAvail;
  logic             inFire;
  logic             outFire;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr_q),
    .gnt_valid (rrValid),
    .gnt_idx   (rrIdx)
  );

  always_comb begin
    candValid = 1'b0;
    candIdx   = '0;
    if (bus.mode == MODE_RR) begin
      candValid = rrValid;
      candIdx   = rrIdx;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (int'(bus.sel) == i && bus.in_valid[i]) begin
          candValid = 1'b1;
          candIdx   = SELW'(i);
        end
      end
    end
    candData = '0;
    for (int i = 0; i < NCH; i++) begin
      if (candIdx == SELW'(i)) candData = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  assign inFire  = candValid && spaceAvail && !reset;
  assign outFire = outValid_q && bus.out_ready;
  assign ptr_d   = (inFire && bus.mode == MODE_RR) ? candIdx : ptr_q;

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.in_ready[i] = inFire && (candIdx == SELW'(i));
    end
  end

  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.out_chan  = outChan_q;

`ifdef MUXARB_SKID_EN
  skid_state_t      state_q;
  logic [WIDTH-1:0] skidData_q;
  logic [SELW-1:0]  skidChan_q;

  assign spaceAvail = (state_q != FULL);

  // The skid slot only fills when the output register is stalled, so order is preserved.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outChan_q  <= '0;
      skidData_q <= '0;
      skidChan_q <= '0;
      ptr_q      <= SELW'(NCH - 1);
    end else begin
      ptr_q <= ptr_d;
      case (state_q)
        EMPTY: begin
          if (inFire) begin
            outData_q  <= candData;
            outChan_q  <= candIdx;
            outValid_q <= 1'b1;
            state_q    <= ONE;
          end
        end
        ONE: begin
          if (inFire && outFire) begin
            outData_q <= candData;
            outChan_q <= candIdx;
          end else if (inFire) begin
            skidData_q <= candData;
            skidChan_q <= candIdx;
            state_q    <= FULL;
          end else if (outFire) begin
            outValid_q <= 1'b0;
            state_q    <= EMPTY;
          end
        end
        FULL: begin
          if (outFire) begin
            outData_q <= skidData_q;
            outChan_q <= skidChan_q;
            state_q   <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end
`else
  assign spaceAvail = !outValid_q || bus.out_ready;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outChan_q  <= '0;
      ptr_q      <= SELW'(NCH - 1);
    end else begin
      ptr_q <= ptr_d;
      if (inFire) begin
        outData_q  <= candData;
        outChan_q  <= candIdx;
        outValid_q <= 1'b1;
      end else if (outFire) begin
        outValid_q <= 1'b0;
      end
    end
  end
`endif

endmodule
